// File: rtl/stc_pkg.sv
// Shared encodings for the sparse tensor core tile sequencer: FSM states,
// core input-valid codes and the packed config word width.
package stc_pkg;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD_A   = 2'd1;
    localparam logic [1:0] ST_STREAM_B = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    localparam logic [1:0] IV_A    = 2'b10;
    localparam logic [1:0] IV_B    = 2'b01;
    localparam logic [1:0] IV_NONE = 2'b00;

    // route + add_en + bypass_en + 6-bit sel per adder + 2-bit edge tag + B count
    function automatic int cfg_w(input int n_unit, input int bcnt_w);
        int lv;
        lv = 2 * $clog2(n_unit) - 1;
        return lv * n_unit + 8 * (n_unit - 1) + 2 * n_unit + bcnt_w;
    endfunction
endpackage

// File: rtl/stc_tile_seq_if.sv
// Host-queue, operand-stream and core-facing signals of the tile sequencer.
interface stc_tile_seq_if #(
    parameter int N_UNIT  = 32,
    parameter int TILE_K  = 8,
    parameter int DW_DATA = 32,
    parameter int BCNT_W  = 8
);
    localparam int N_ADDERS = N_UNIT - 1;
    localparam int N_LEVELS = 2 * $clog2(N_UNIT) - 1;

    logic                         cfg_valid, cfg_ready;
    logic [N_LEVELS*N_UNIT-1:0]   cfg_route, core_route;
    logic [N_ADDERS-1:0]          cfg_add_en, core_add_en;
    logic [N_ADDERS-1:0]          cfg_bypass_en, core_bypass_en;
    logic [6*N_ADDERS-1:0]        cfg_sel, core_sel;
    logic [2*N_UNIT-1:0]          cfg_edge_tag, core_edge_tag;
    logic [BCNT_W-1:0]            cfg_n_b;
    logic                         a_valid, a_ready, b_valid, b_ready;
    logic [N_UNIT*DW_DATA-1:0]    a_data, core_in_a;
    logic [TILE_K*DW_DATA-1:0]    b_data, core_in_b;
    logic                         core_enable, busy, tile_done;
    logic [1:0]                   core_in_valid;
    logic [7:0]                   tile_cnt;

    modport slave (
        input  cfg_valid, cfg_route, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_edge_tag, cfg_n_b,
        input  a_valid, a_data, b_valid, b_data,
        output cfg_ready, a_ready, b_ready,
        output core_enable, core_in_valid, core_in_a, core_in_b,
        output core_route, core_add_en, core_bypass_en, core_sel, core_edge_tag,
        output busy, tile_done, tile_cnt
    );

    modport master (
        output cfg_valid, cfg_route, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_edge_tag, cfg_n_b,
        output a_valid, a_data, b_valid, b_data,
        input  cfg_ready, a_ready, b_ready,
        input  core_enable, core_in_valid, core_in_a, core_in_b,
        input  core_route, core_add_en, core_bypass_en, core_sel, core_edge_tag,
        input  busy, tile_done, tile_cnt
    );
endinterface

// File: rtl/stc_cfg_fifo.sv
// Small config-word FIFO; push is refused when full even if a pop happens the same cycle.
module stc_cfg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_q, rd_q;
    logic [AW:0]             cnt_q;
    logic                    do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/stc_tile_seq.sv
// Tile sequencer: pops a config per tile, feeds one A beat and n_b B beats to the
// core with registered outputs, then drains for a fixed latency and pulses tile_done.
module stc_tile_seq
    import stc_pkg::*;
#(
    parameter int N_UNIT    = 32,
    parameter int TILE_K    = 8,
    parameter int DW_DATA   = 32,
    parameter int CFG_DEPTH = 2,
    parameter int BCNT_W    = 8,
    parameter int DRAIN_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    stc_tile_seq_if.slave bus
);
    localparam int CW  = cfg_w(N_UNIT, BCNT_W);
    localparam int DCW = $clog2(DRAIN_LAT + 1);

    logic [CW-1:0]               fifo_din, fifo_dout, cfg_q, cfg_d;
    logic                        fifo_full, fifo_empty, push, pop, rdy_q;
    logic [1:0]                  state_q, state_d, iv_q, iv_d;
    logic [N_UNIT*DW_DATA-1:0]   a_q, a_d;
    logic [TILE_K*DW_DATA-1:0]   b_q, b_d;
    logic [BCNT_W-1:0]           bcnt_q, bcnt_d, n_b;
    logic [DCW-1:0]              dcnt_q, dcnt_d;
    logic                        done_q, done_d;
    logic [7:0]                  tcnt_q, tcnt_d;

    assign fifo_din = {bus.cfg_route, bus.cfg_add_en, bus.cfg_bypass_en,
                       bus.cfg_sel, bus.cfg_edge_tag, bus.cfg_n_b};
    // rdy_q keeps cfg_ready low while reset is held and for no longer
    assign push          = bus.cfg_valid && rdy_q && !fifo_full;
    assign bus.cfg_ready = rdy_q && !fifo_full;

    stc_cfg_fifo #(.W(CW), .DEPTH(CFG_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .din_i  (fifo_din),
        .pop_i  (pop),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign {bus.core_route, bus.core_add_en, bus.core_bypass_en,
            bus.core_sel, bus.core_edge_tag, n_b} = cfg_q;
    assign bus.a_ready       = (state_q == ST_LOAD_A);
    assign bus.b_ready       = (state_q == ST_STREAM_B);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.core_enable   = (state_q != ST_IDLE);
    assign bus.core_in_valid = iv_q;
    assign bus.core_in_a     = a_q;
    assign bus.core_in_b     = b_q;
    assign bus.tile_done     = done_q;
    assign bus.tile_cnt      = tcnt_q;

    always_comb begin
        state_d = state_q;
        iv_d    = IV_NONE;
        a_d     = a_q;
        b_d     = '0;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;
        tcnt_d  = tcnt_q;
        cfg_d   = cfg_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                cfg_d   = fifo_dout;
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A: if (bus.a_valid) begin
                iv_d    = IV_A;
                a_d     = bus.a_data;
                bcnt_d  = '0;
                dcnt_d  = '0;
                state_d = (n_b == '0) ? ST_DRAIN : ST_STREAM_B;
            end
            ST_STREAM_B: if (bus.b_valid) begin
                iv_d   = IV_B;
                b_d    = bus.b_data;
                bcnt_d = bcnt_q + BCNT_W'(1);
                if (bcnt_q == n_b - BCNT_W'(1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q + DCW'(1);
                if (dcnt_q == DCW'(DRAIN_LAT - 1)) begin
                    done_d = 1'b1;
                    tcnt_d = tcnt_q + 8'd1;
                    // back-to-back tiles skip IDLE entirely
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        cfg_d   = fifo_dout;
                        state_d = ST_LOAD_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            iv_q    <= IV_NONE;
            a_q     <= '0;
            b_q     <= '0;
            bcnt_q  <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            tcnt_q  <= '0;
            cfg_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iv_q    <= iv_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bcnt_q  <= bcnt_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            tcnt_q  <= tcnt_d;
            cfg_q   <= cfg_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stc_tile_seq.sv
// Directed bench for stc_tile_seq: single tiles, stalls, back-to-back tiles,
// empty B stream, full config queue and mid-tile reset.
module tb_stc_tile_seq;
    localparam int NU = 32;
    localparam int NL = 9;
    localparam int NA = 31;

    typedef logic [1023:0] v_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    stc_tile_seq_if bus ();
    stc_tile_seq dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input v_t got, input v_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [NL*32-1:0] rt(input int id);
        return {NL{32'hC0DE_0000 | 32'(id)}};
    endfunction
    function automatic logic [1023:0] av(input int id);
        return {32{32'hA000_0000 | 32'(id)}};
    endfunction
    function automatic logic [255:0] bv(input int k);
        return {8{32'hB000_0000 | 32'(k)}};
    endfunction

    task automatic set_cfg(input int id, input int nb);
        bus.cfg_route     = rt(id);
        bus.cfg_add_en    = NA'(id * 7 + 1);
        bus.cfg_bypass_en = NA'(id * 3 + 2);
        bus.cfg_sel       = {NA{6'(id)}};
        bus.cfg_edge_tag  = {NU{2'(id)}};
        bus.cfg_n_b       = 8'(nb);
    endtask

    task automatic chk_cfg(input string tag, input int id);
        chk({tag, ".route"}, v_t'(bus.core_route), v_t'(rt(id)));
        chk({tag, ".add"}, v_t'(bus.core_add_en), v_t'(NA'(id * 7 + 1)));
        chk({tag, ".byp"}, v_t'(bus.core_bypass_en), v_t'(NA'(id * 3 + 2)));
        chk({tag, ".sel"}, v_t'(bus.core_sel), v_t'({NA{6'(id)}}));
        chk({tag, ".tag"}, v_t'(bus.core_edge_tag), v_t'({NU{2'(id)}}));
    endtask

    // one clock: check core_in_valid, tile_done and (optionally) core_in_b
    task automatic cyc(input string tag, input logic [1:0] iv, input logic [255:0] b,
                       input logic done, input bit cb);
        @(negedge clk);
        chk({tag, ".iv"}, v_t'(bus.core_in_valid), v_t'(iv));
        chk({tag, ".done"}, v_t'(bus.tile_done), v_t'(done));
        if (cb) chk({tag, ".b"}, v_t'(bus.core_in_b), v_t'(b));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) cyc({tag, ".drn"}, 2'b00, '0, 1'b0, 1'b1);
        cyc({tag, ".end"}, 2'b00, '0, 1'b1, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tile_done && k < lim);
        chk({tag, ".seen"}, v_t'(bus.tile_done), v_t'(1));
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_data = '0;
        bus.b_data = '0;
        set_cfg(0, 0);
        repeat (2) @(negedge clk);
        chk("rst.rdy", v_t'(bus.cfg_ready), v_t'(0));
        chk("rst.busy", v_t'(bus.busy), v_t'(0));
        chk("rst.en", v_t'(bus.core_enable), v_t'(0));
        chk("rst.iv", v_t'(bus.core_in_valid), v_t'(0));
        chk("rst.done", v_t'(bus.tile_done), v_t'(0));
        chk("rst.cnt", v_t'(bus.tile_cnt), v_t'(0));
        chk("rst.ardy", v_t'(bus.a_ready), v_t'(0));
        chk("rst.route", v_t'(bus.core_route), v_t'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst.rdy_up", v_t'(bus.cfg_ready), v_t'(1));

        // T1: n_b=3, everything back-to-back
        set_cfg(1, 3);
        bus.cfg_valid = 1'b1;
        bus.a_valid = 1'b1; bus.a_data = av(1);
        bus.b_valid = 1'b1; bus.b_data = bv(0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("t1.idle", v_t'(bus.busy), v_t'(0));
        cyc("t1.la", 2'b00, '0, 1'b0, 1'b0);
        chk("t1.busy", v_t'(bus.busy), v_t'(1));
        chk("t1.en", v_t'(bus.core_enable), v_t'(1));
        chk("t1.ardy", v_t'(bus.a_ready), v_t'(1));
        chk_cfg("t1.cfg", 1);
        cyc("t1.a", 2'b10, '0, 1'b0, 1'b0);
        chk("t1.in_a", v_t'(bus.core_in_a), v_t'(av(1)));
        chk("t1.brdy", v_t'(bus.b_ready), v_t'(1));
        chk("t1.ardy0", v_t'(bus.a_ready), v_t'(0));
        cyc("t1.b0", 2'b01, bv(0), 1'b0, 1'b1); bus.b_data = bv(1);
        cyc("t1.b1", 2'b01, bv(1), 1'b0, 1'b1); bus.b_data = bv(2);
        cyc("t1.b2", 2'b01, bv(2), 1'b0, 1'b1);
        drain("t1");
        chk("t1.cnt", v_t'(bus.tile_cnt), v_t'(1));
        chk("t1.busy0", v_t'(bus.busy), v_t'(0));
        chk("t1.ahold", v_t'(bus.core_in_a), v_t'(av(1)));

        // T2: two-cycle B starvation mid-stream
        set_cfg(2, 3);
        bus.cfg_valid = 1'b1;
        bus.a_data = av(2);
        bus.b_data = bv(16);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("t2.doneclr", v_t'(bus.tile_done), v_t'(0));
        cyc("t2.la", 2'b00, '0, 1'b0, 1'b0);
        cyc("t2.a", 2'b10, '0, 1'b0, 1'b0);
        chk("t2.in_a", v_t'(bus.core_in_a), v_t'(av(2)));
        cyc("t2.b0", 2'b01, bv(16), 1'b0, 1'b1); bus.b_valid = 1'b0;
        cyc("t2.bub0", 2'b00, '0, 1'b0, 1'b1);
        chk("t2.en0", v_t'(bus.core_enable), v_t'(1));
        cyc("t2.bub1", 2'b00, '0, 1'b0, 1'b1);
        chk("t2.en1", v_t'(bus.core_enable), v_t'(1));
        bus.b_valid = 1'b1; bus.b_data = bv(17);
        cyc("t2.b1", 2'b01, bv(17), 1'b0, 1'b1); bus.b_data = bv(18);
        cyc("t2.b2", 2'b01, bv(18), 1'b0, 1'b1);
        drain("t2");
        chk("t2.cnt", v_t'(bus.tile_cnt), v_t'(2));

        // T3: two queued configs, inputs always valid
        set_cfg(3, 1);
        bus.cfg_valid = 1'b1;
        bus.a_data = av(3);
        bus.b_data = bv(32);
        @(negedge clk);
        set_cfg(4, 2);
        cyc("t3.la", 2'b00, '0, 1'b0, 1'b0);
        bus.cfg_valid = 1'b0;
        chk_cfg("t3.c3", 3);
        cyc("t3.a", 2'b10, '0, 1'b0, 1'b0);
        cyc("t3.b0", 2'b01, bv(32), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("t3.drn", 2'b00, '0, 1'b0, 1'b1);
        chk("t3.rt_hold", v_t'(bus.core_route), v_t'(rt(3)));
        cyc("t3.end", 2'b00, '0, 1'b1, 1'b1);
        chk_cfg("t3.c4", 4);
        chk("t3.busy", v_t'(bus.busy), v_t'(1));
        chk("t3.ardy", v_t'(bus.a_ready), v_t'(1));
        chk("t3.cnt1", v_t'(bus.tile_cnt), v_t'(3));
        cyc("t3.a2", 2'b10, '0, 1'b0, 1'b0);
        cyc("t3.b20", 2'b01, bv(32), 1'b0, 1'b1);
        cyc("t3.b21", 2'b01, bv(32), 1'b0, 1'b1);
        drain("t3b");
        chk("t3.cnt2", v_t'(bus.tile_cnt), v_t'(4));
        chk("t3.busy0", v_t'(bus.busy), v_t'(0));

        // T4: empty B stream
        set_cfg(5, 0);
        bus.cfg_valid = 1'b1;
        bus.a_data = av(5);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        cyc("t4.la", 2'b00, '0, 1'b0, 1'b0);
        chk("t4.brdy0", v_t'(bus.b_ready), v_t'(0));
        cyc("t4.a", 2'b10, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t4.brdy", v_t'(bus.b_ready), v_t'(0));
            cyc("t4.drn", 2'b00, '0, 1'b0, 1'b1);
        end
        chk("t4.brdy3", v_t'(bus.b_ready), v_t'(0));
        cyc("t4.end", 2'b00, '0, 1'b1, 1'b1);
        chk("t4.cnt", v_t'(bus.tile_cnt), v_t'(5));

        // T5: fill the queue while the tile stalls on A
        bus.a_valid = 1'b0;
        set_cfg(6, 0);
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        set_cfg(7, 0);
        @(negedge clk);
        chk("t5.rdy1", v_t'(bus.cfg_ready), v_t'(1));
        set_cfg(8, 0);
        @(negedge clk);
        chk("t5.full", v_t'(bus.cfg_ready), v_t'(0));
        set_cfg(9, 0);
        @(negedge clk);
        chk("t5.full2", v_t'(bus.cfg_ready), v_t'(0));
        chk("t5.stall_iv", v_t'(bus.core_in_valid), v_t'(0));
        chk("t5.rt6", v_t'(bus.core_route), v_t'(rt(6)));
        bus.a_valid = 1'b1;
        cyc("t5.a", 2'b10, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("t5.drn", 2'b00, '0, 1'b0, 1'b1);
        chk("t5.full3", v_t'(bus.cfg_ready), v_t'(0));
        cyc("t5.end", 2'b00, '0, 1'b1, 1'b1);
        chk("t5.rdy_pop", v_t'(bus.cfg_ready), v_t'(1));
        chk("t5.rt7", v_t'(bus.core_route), v_t'(rt(7)));
        @(negedge clk);
        chk("t5.refull", v_t'(bus.cfg_ready), v_t'(0));
        bus.cfg_valid = 1'b0;
        wait_done("t5.d7", 10);
        chk("t5.rt8", v_t'(bus.core_route), v_t'(rt(8)));
        wait_done("t5.d8", 10);
        chk("t5.rt9", v_t'(bus.core_route), v_t'(rt(9)));
        wait_done("t5.d9", 10);
        repeat (8) @(negedge clk);
        chk("t5.idle", v_t'(bus.busy), v_t'(0));
        chk("t5.cnt", v_t'(bus.tile_cnt), v_t'(9));

        // T6: reset in the middle of the B stream with a config still queued
        set_cfg(10, 5);
        bus.cfg_valid = 1'b1;
        bus.a_data = av(10);
        bus.b_data = bv(48);
        @(negedge clk);
        set_cfg(11, 2);
        cyc("t6.la", 2'b00, '0, 1'b0, 1'b0);
        bus.cfg_valid = 1'b0;
        cyc("t6.a", 2'b10, '0, 1'b0, 1'b0);
        cyc("t6.b0", 2'b01, bv(48), 1'b0, 1'b1);
        chk("t6.brdy", v_t'(bus.b_ready), v_t'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6.iv", v_t'(bus.core_in_valid), v_t'(0));
        chk("t6.busy", v_t'(bus.busy), v_t'(0));
        chk("t6.en", v_t'(bus.core_enable), v_t'(0));
        chk("t6.brdy0", v_t'(bus.b_ready), v_t'(0));
        chk("t6.in_a", v_t'(bus.core_in_a), v_t'(0));
        chk("t6.in_b", v_t'(bus.core_in_b), v_t'(0));
        chk("t6.route", v_t'(bus.core_route), v_t'(0));
        chk("t6.cnt", v_t'(bus.tile_cnt), v_t'(0));
        chk("t6.rdy", v_t'(bus.cfg_ready), v_t'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6.q_empty", v_t'(bus.busy), v_t'(0));
            chk("t6.nodone", v_t'(bus.tile_done), v_t'(0));
        end
        chk("t6.rdy_up", v_t'(bus.cfg_ready), v_t'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
